// File: rtl/fp_status_monitor.sv
// fp_status_monitor: periodic consistency checker for the FP multiplier
// status bus. It samples operands, result, rounding mode and status flags
// every PERIOD enabled cycles, evaluates 19 checks, and reports a registered
// per-check mask, a sticky error with first-error ID and a saturating count.
module fp_status_monitor #(
  parameter int W       = 32,
  parameter int EXP_W   = 8,
  parameter int PERIOD  = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     z,
  input  logic [2:0]       rnd,
  input  logic [7:0]       status,
  output logic             sample_o,
  output logic [18:0]      viol_o,
  output logic             err_o,
  output logic [4:0]       first_id_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int M    = W - 1 - EXP_W;
  localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

  // Lowest set bit of a violation mask; this becomes the reported check ID.
  function automatic logic [4:0] f_lowest_id(input logic [18:0] m);
    f_lowest_id = '0;
    for (int i = 18; i >= 0; i--) begin
      if (m[i]) f_lowest_id = 5'(i);
    end
  endfunction

  // Counter increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    if (&c) f_sat_inc = c;
    else    f_sat_inc = c + 1'b1;
  endfunction

  logic [PH_W-1:0] r_phase;
  logic            w_sample;
  logic [W-1:0]    w_tail_a;
  logic [W-1:0]    w_tail_b;
  logic            w_tail_vld;
  logic [18:0]     w_mask;

  assign w_sample = en && (r_phase == PH_LAST);

  // Phase counter: 0..PERIOD-1, advancing only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (en) begin
      if (r_phase == PH_LAST) r_phase <= '0;
      else                    r_phase <= r_phase + 1'b1;
    end
  end

  // ---- operand delay line: aligns a/b with the status they produced ----
  generate
    if (LATENCY > 0) begin : g_dly
      logic [W-1:0]       r_dly_a [LATENCY];
      logic [W-1:0]       r_dly_b [LATENCY];
      logic [LATENCY-1:0] r_dly_vld;

      // Operand data shifts on enable; it needs no reset because the valid
      // tags decide whether the tail is trusted.
      always_ff @(posedge clk) begin
        if (en) begin
          r_dly_a[0] <= a;
          r_dly_b[0] <= b;
          for (int i = 1; i < LATENCY; i++) begin
            r_dly_a[i] <= r_dly_a[i-1];
            r_dly_b[i] <= r_dly_b[i-1];
          end
        end
      end

      // Valid tags: emptied on reset, filled with ones from the head.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dly_vld <= '0;
        end else if (en) begin
          r_dly_vld[0] <= 1'b1;
          for (int i = 1; i < LATENCY; i++) begin
            r_dly_vld[i] <= r_dly_vld[i-1];
          end
        end
      end

      assign w_tail_a   = r_dly_a[LATENCY-1];
      assign w_tail_b   = r_dly_b[LATENCY-1];
      assign w_tail_vld = r_dly_vld[LATENCY-1];
    end else begin : g_nodly
      assign w_tail_a   = a;
      assign w_tail_b   = b;
      assign w_tail_vld = 1'b1;
    end
  endgenerate

  // ---- check evaluation on the sample-cycle inputs ----
  logic [EXP_W-1:0] w_z_exp;
  logic [M-1:0]     w_z_man;
  logic             w_ea_zero, w_ea_ones, w_eb_zero, w_eb_ones;

  assign w_z_exp   = z[W-2:M];
  assign w_z_man   = z[M-1:0];
  assign w_ea_zero = (w_tail_a[W-2:M] == '0);
  assign w_ea_ones = &w_tail_a[W-2:M];
  assign w_eb_zero = (w_tail_b[W-2:M] == '0);
  assign w_eb_ones = &w_tail_b[W-2:M];

  // Sign bits and operand mantissas play no part in any check.
  logic w_unused;
  assign w_unused = ^{w_tail_a[W-1], w_tail_a[M-1:0],
                      w_tail_b[W-1], w_tail_b[M-1:0], z[W-1]};

  // Violation mask: flag-exclusivity pairs, encoding rules, zero*inf rule.
  always_comb begin
    w_mask     = '0;
    w_mask[0]  = status[0] & status[1];
    w_mask[1]  = status[0] & status[2];
    w_mask[2]  = status[0] & status[3];
    w_mask[3]  = status[0] & status[4];
    w_mask[4]  = status[1] & status[3];
    w_mask[5]  = status[2] & status[3];
    w_mask[6]  = status[2] & status[4];
    w_mask[7]  = status[2] & status[5];
    w_mask[8]  = status[2] & status[6];
    w_mask[9]  = status[2] & status[7];
    w_mask[10] = status[3] & status[4];
    w_mask[11] = status[3] & status[6];
    w_mask[12] = status[4] & status[7];
    w_mask[13] = status[6] & status[7];
    w_mask[14] = status[0] && (z[W-2:0] != '0);
    w_mask[15] = status[1] && (z[W-2:0] != {{EXP_W{1'b1}}, {M{1'b0}}});
    w_mask[16] = w_tail_vld && !status[2] &&
                 ((w_ea_zero && w_eb_ones) || (w_ea_ones && w_eb_zero));
    w_mask[17] = status[2] && (!(&w_z_exp) || (w_z_man == '0));
    w_mask[18] = (rnd > 3'd4);
  end

  // ---- report stage: registered one cycle after the sample ----
  // Reporting registers; a violation registering together with clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_o   <= 1'b0;
      viol_o     <= '0;
      err_o      <= 1'b0;
      first_id_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      sample_o <= w_sample;
      if (w_sample) viol_o <= w_mask;
      if (w_sample && (w_mask != '0)) begin
        if (clear) begin
          err_o      <= 1'b1;
          first_id_o <= f_lowest_id(w_mask);
          err_cnt_o  <= CNT_W'(1);
        end else begin
          err_cnt_o <= f_sat_inc(err_cnt_o);
          if (!err_o) begin
            err_o      <= 1'b1;
            first_id_o <= f_lowest_id(w_mask);
          end
        end
      end else if (clear) begin
        err_o      <= 1'b0;
        first_id_o <= '0;
        err_cnt_o  <= '0;
      end
    end
  end

endmodule

// File: doc/fp_status_monitor.md
Name: fp_status_monitor

Overview:
Synthesizable, parametrised run-time checker for the floating-point multiplier status bus. It samples the multiplier's operands, result, rounding mode and 8-bit status once every PERIOD cycles, and evaluates 19 consistency checks: flag-exclusivity pairs, result-encoding rules and the zero×inf→NaN rule. Violations are reported as a registered per-check mask, a sticky error with first-error ID, and a saturating error counter. It sits beside the multiplier in both the testbench and the silicon debug wrapper.

Parameters:
W, 32, operand/result width
EXP_W, 8, exponent width; mantissa width M = W-1-EXP_W
PERIOD, 4, sampling period in cycles (>=1)
LATENCY, 2, operand-to-status delay in cycles (>=0; 0 = no delay line)
CNT_W, 16, error counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  monitor enable; sampling and the delay line advance only when en=1
clear  in  1  sync clear of sticky error, first ID and counter
a  in  W  operand A
b  in  W  operand B
z  in  W  result
rnd  in  3  rounding mode
status  in  8  bit i: 0 zero, 1 inf, 2 nan, 3 tiny, 4 huge, 5 inexact, 6 overflow, 7 underflow
sample_o  out  1  one-cycle pulse: a sample was taken this cycle
viol_o  out  19  per-check violation mask for the last sample, registered
err_o  out  1  sticky: some violation since reset/clear
first_id_o  out  5  lowest check ID of the first violating sample
err_cnt_o  out  CNT_W  count of violating samples, saturating

Behaviour:
- Reset (rst=1): all outputs 0; phase counter 0; delay line emptied (all valid tags 0). rst has priority over every other input.
- Phase counter: counts 0..PERIOD-1 and wraps; it advances only when en=1. When en=1 and phase==PERIOD-1, a sample is taken. With PERIOD=1, every enabled cycle is a sample.
- Delay line: LATENCY stages holding {a, b, valid}. It shifts on en=1 and inserts valid=1 at the head. Check C16 uses the tail stage; with LATENCY=0 it uses a/b directly with valid=1.
- Checks (ID: violation condition, evaluated on sample-cycle inputs):
  - 0-13, flag pairs both set: 0-1, 0-2, 0-3, 0-4, 1-3, 2-3, 2-4, 2-5, 2-6, 2-7, 3-4, 3-6, 4-7, 6-7 (IDs in that order).
  - 14: zero=1 and z[W-2:0]!=0.
  - 15: inf=1 and z[W-2:0] != {EXP_W ones, M zeros}.
  - 16: tail valid=1 and one operand has an all-zero exponent while the other has an all-ones exponent, and nan=0.
  - 17: nan=1 and (z exponent not all ones, or z mantissa == 0).
  - 18: rnd > 4.
- Registered reporting, one cycle after the sample cycle:
  - sample_o=1 and viol_o=mask. Otherwise sample_o=0 and viol_o holds its last value.
  - If mask!=0: err_cnt_o increments (saturating at all ones).
  - If mask!=0 and err_o was 0: err_o=1 and first_id_o=lowest set bit of mask. Later violations do not change first_id_o.
- Clear:
  - clear=1 zeroes err_o, first_id_o and err_cnt_o. It does not touch viol_o, the phase counter or the delay line.
  - If a violating mask registers in the same cycle as clear, the new event wins: err_o=1, first_id_o=its ID, err_cnt_o=1.
- en=0 mid-period: the phase counter and delay line freeze, no sample is taken, and outputs hold.
- Latency from sample to report: 1 cycle.

Test Plan:
- rst, then en=1 with status=8'h00, a=b=z=0, rnd=0 for 12 cycles -> sample_o pulses in cycles 4, 8, 12 after reset release; viol_o=0; err_o=0; err_cnt_o=0.
- On a sample cycle drive status bits 0 and 1 set (zero+inf) and z=0 -> next cycle viol_o bit0=1 and bit15=1 (z is not an inf encoding); err_o=1; first_id_o=0; err_cnt_o=1.
- LATENCY=2: a=32'h00000000, b=32'h7F800000 two cycles before a sample, nan=0 at the sample -> viol_o[16]=1. Repeat with nan=1 and z=32'h7FC00000 -> viol_o=0.
- Drive violating samples continuously with CNT_W=2 -> err_cnt_o goes 1, 2, 3, 3 (saturates); first_id_o stays at its first value.
- Assert clear in the same cycle a rnd=5 violation registers -> err_o=1, first_id_o=18, err_cnt_o=1.
- rst mid-period at phase 2 with a zero/inf operand pair in the delay line -> all outputs 0, no C16 violation at the next sample, first sample_o exactly PERIOD cycles after release.
